intr_ctrl: RTL

//  Memory-mapped interrupt controller that shares the single CPU IRQ line among up to NUM_SRC

---
 rtl/intr_ctrl_pkg.sv | 29 ++
 rtl/intr_ctrl_if.sv | 22 ++
 rtl/intr_ctrl_prio.sv | 24 ++
 rtl/intr_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// Interrupt controller shared definitions.
// Register offsets, FSM encoding and vector word helper.
package intr_ctrl_pkg;

  localparam logic [11:0] ADDR_ENABLE = 12'h000;
  localparam logic [11:0] ADDR_PEND   = 12'h100;
  localparam logic [11:0] ADDR_VECTOR = 12'h200;
  localparam logic [11:0] ADDR_EOI    = 12'h300;
  localparam logic [11:0] ADDR_CLR    = 12'h400;

  localparam int VEC_VALID_BIT = 31;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    IN_SERVICE = 2'd2
  } state_t;

  function automatic logic [31:0] vec_word(
    input logic        valid,
    input logic [31:0] idx
  );
    logic [31:0] w;
    w = idx;
    w[VEC_VALID_BIT] = valid;
    return w;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-side register bus of the interrupt controller.
// Active-low strobes shared with the timer block.
interface intr_ctrl_if;

  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (
    output CS_N, RD_N, WR_N, Addr, DataIn,
    input  DataOut
  );

  modport slave (
    input  CS_N, RD_N, WR_N, Addr, DataIn,
    output DataOut
  );

endinterface

// File: rtl/intr_ctrl_prio.sv
// Fixed-priority encoder, index 0 wins.
// Purely combinational.
module prio_enc #(
  parameter int N = 8,
  parameter int W = 5
) (
  input  logic [N-1:0] req_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  // scan from the top so the lowest set index is written last
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        any_o = 1'b1;
        idx_o = W'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge latch, mask, priority,
// single IRQ line with ack/EOI handshake.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  intr_ctrl_if.slave         bus,
  input  logic [NUM_SRC-1:0] Src_N,
  output logic               IRQ_N
);

  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [IDX_W-1:0]   insvc_q, insvc_d;
  state_t             state_q, state_d;

  logic               rd, wr;
  logic               a_en, a_pend, a_vec;
  logic               a_eoi, a_clr;
  logic [NUM_SRC-1:0] req, set_m, clr_m, ack_m;
  logic               any;
  logic [IDX_W-1:0]   win;
  logic               ack;
  logic               unused_data;

  assign unused_data = ^bus.DataIn;

  // a write during a read strobe is dropped
  assign rd = !bus.CS_N && !bus.RD_N;
  assign wr = !bus.CS_N && !bus.WR_N && bus.RD_N;

  assign a_en   = bus.Addr == ADDR_ENABLE;
  assign a_pend = bus.Addr == ADDR_PEND;
  assign a_vec  = bus.Addr == ADDR_VECTOR;
  assign a_eoi  = bus.Addr == ADDR_EOI;
  assign a_clr  = bus.Addr == ADDR_CLR;

  assign req   = pend_q & enable_q;
  assign set_m = prev_q & ~Src_N;

  prio_enc #(
    .N (NUM_SRC),
    .W (IDX_W)
  ) u_prio (
    .req_i (req),
    .any_o (any),
    .idx_o (win)
  );

  assign ack = (state_q == ASSERT) && any
             && rd && a_vec;

  assign ack_m = ack ? (NUM_SRC'(1) << win) : '0;
  assign clr_m = (wr && a_clr)
               ? bus.DataIn[NUM_SRC-1:0] : '0;

  // new edges win over any clear in the same cycle
  always_comb begin
    pend_d   = (pend_q & ~(clr_m | ack_m)) | set_m;
    enable_d = enable_q;
    if (wr && a_en) enable_d = bus.DataIn[NUM_SRC-1:0];
    insvc_d  = ack ? win : insvc_q;
  end

  // register state, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q <= '0;
      pend_q   <= '0;
      prev_q   <= '1;
      insvc_q  <= '0;
      state_q  <= IDLE;
    end else begin
      enable_q <= enable_d;
      pend_q   <= pend_d;
      prev_q   <= Src_N;
      insvc_q  <= insvc_d;
      state_q  <= state_d;
    end
  end

  // request/acknowledge FSM next state and IRQ line
  always_comb begin
    state_d = state_q;
    IRQ_N   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (|req) state_d = ASSERT;
      end
      ASSERT: begin
        IRQ_N = 1'b0;
        if (!any)     state_d = IDLE;
        else if (ack) state_d = IN_SERVICE;
      end
      IN_SERVICE: begin
        if (wr && a_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // read data mux, zero when not read-selected
  always_comb begin
    bus.DataOut = '0;
    if (rd) begin
      unique case (1'b1)
        a_en:   bus.DataOut = 32'(enable_q);
        a_pend: bus.DataOut = 32'(pend_q);
        a_vec: begin
          if (state_q == ASSERT)
            bus.DataOut = vec_word(any, 32'(win));
          else if (state_q == IN_SERVICE)
            bus.DataOut = vec_word(1'b1, 32'(insvc_q));
        end
        default: bus.DataOut = '0;
      endcase
    end
  end

endmodule
